// File: rtl/neuron_weight_update_pkg.sv
// Shared types, limits and saturation helper for the neuron training datapath.
package neuron_pkg;

  typedef enum logic [1:0] {IDLE, DELTA, UPDATE, BIAS} state_t;

  localparam int DATA_WIDTH = 8;
  localparam int MAX_VAL    = 2 ** (DATA_WIDTH - 1) - 1;
  localparam int MIN_VAL    = -(2 ** (DATA_WIDTH - 1));

  // Clamp a wide signed value into the signed range of a width-bit word.
  function automatic logic signed [31:0] sat(input logic signed [31:0] value, input int width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/neuron_weight_update_if.sv
// Request/response bundle between the training controller and one weight-update block.
interface neuron_weight_update_if #(
  parameter int NUM_INPUTS = 1,
  parameter int WIDTH      = 8
);

  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN;
  logic [NUM_INPUTS*WIDTH-1:0] WEIGHTS_IN;
  logic [WIDTH-1:0]            BIAS_IN;
  logic [WIDTH-1:0]            ERROR_IN;
  logic [WIDTH-1:0]            ACT_DERIV_IN;
  logic                        VALID_IN;
  logic                        READY_OUT;
  logic [NUM_INPUTS*WIDTH-1:0] WEIGHTS_OUT;
  logic [WIDTH-1:0]            BIAS_OUT;
  logic [WIDTH-1:0]            DELTA_OUT;
  logic                        VALID_OUT;

  modport master (
    output VALUES_IN, WEIGHTS_IN, BIAS_IN, ERROR_IN, ACT_DERIV_IN, VALID_IN,
    input  READY_OUT, WEIGHTS_OUT, BIAS_OUT, DELTA_OUT, VALID_OUT
  );

  modport slave (
    input  VALUES_IN, WEIGHTS_IN, BIAS_IN, ERROR_IN, ACT_DERIV_IN, VALID_IN,
    output READY_OUT, WEIGHTS_OUT, BIAS_OUT, DELTA_OUT, VALID_OUT
  );

endinterface

// File: rtl/neuron_weight_update_mul.sv
// Combinational fixed-point multiply: full product, floor shift by FRAC_BITS, saturate.
module fixed_point_sat_mul
  import neuron_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAC_BITS = 3
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] product
);

  logic signed [2*WIDTH-1:0] full_product;
  logic signed [2*WIDTH-1:0] shifted;

  assign full_product = (2*WIDTH)'(a) * (2*WIDTH)'(b);
  assign shifted      = full_product >>> FRAC_BITS;
  assign product      = WIDTH'(sat(32'(shifted), WIDTH));

endmodule

// File: rtl/neuron_weight_update.sv
// Backward-pass SGD update for one neuron: delta, then one weight per cycle, then bias.
module neuron_weight_update
  import neuron_pkg::*;
#(
  parameter int NUM_INPUTS = 1,
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3,
  parameter int LR_SHIFT   = 3
) (
  input logic                  CLK,
  input logic                  RST,
  neuron_weight_update_if.slave bus
);

  localparam int                IDX_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_t state;
  state_t next_state;

  logic [IDX_W-1:0]            idx;
  logic signed [WIDTH-1:0]     x_reg [NUM_INPUTS];
  logic signed [WIDTH-1:0]     w_reg [NUM_INPUTS];
  logic signed [WIDTH-1:0]     bias_reg;
  logic signed [WIDTH-1:0]     error_reg;
  logic signed [WIDTH-1:0]     deriv_reg;
  logic signed [WIDTH-1:0]     delta_reg;
  logic [NUM_INPUTS*WIDTH-1:0] weights_out;
  logic signed [WIDTH-1:0]     bias_out;
  logic signed [WIDTH-1:0]     delta_out;
  logic                        valid_out;
  logic                        ready;

  logic signed [WIDTH-1:0]     mul_a;
  logic signed [WIDTH-1:0]     mul_b;
  logic signed [WIDTH-1:0]     mul_p;
  logic signed [WIDTH:0]       w_diff;
  logic signed [WIDTH:0]       b_diff;
  logic signed [WIDTH-1:0]     w_next;
  logic signed [WIDTH-1:0]     b_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.VALID_IN) next_state = DELTA;
      DELTA:   next_state = UPDATE;
      UPDATE:  if (idx == LAST_IDX) next_state = BIAS;
      BIAS:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The single multiplier computes delta in DELTA and the per-weight gradient in UPDATE.
  always_comb begin
    ready = (state == IDLE);
    mul_a = delta_reg;
    mul_b = x_reg[idx];
    if (state == DELTA) begin
      mul_a = error_reg;
      mul_b = deriv_reg;
    end
  end

  fixed_point_sat_mul #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .a       (mul_a),
    .b       (mul_b),
    .product (mul_p)
  );

  assign w_diff = (WIDTH+1)'(w_reg[idx]) - (WIDTH+1)'(mul_p >>> LR_SHIFT);
  assign b_diff = (WIDTH+1)'(bias_reg) - (WIDTH+1)'(delta_reg >>> LR_SHIFT);
  assign w_next = WIDTH'(sat(32'(w_diff), WIDTH));
  assign b_next = WIDTH'(sat(32'(b_diff), WIDTH));

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx         <= '0;
      bias_reg    <= '0;
      error_reg   <= '0;
      deriv_reg   <= '0;
      delta_reg   <= '0;
      weights_out <= '0;
      bias_out    <= '0;
      delta_out   <= '0;
      valid_out   <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        x_reg[i] <= '0;
        w_reg[i] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.VALID_IN) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              x_reg[i] <= bus.VALUES_IN[i*WIDTH +: WIDTH];
              w_reg[i] <= bus.WEIGHTS_IN[i*WIDTH +: WIDTH];
            end
            bias_reg  <= bus.BIAS_IN;
            error_reg <= bus.ERROR_IN;
            deriv_reg <= bus.ACT_DERIV_IN;
          end
        end
        DELTA: begin
          delta_reg <= mul_p;
          idx       <= '0;
        end
        UPDATE: begin
          weights_out[idx*WIDTH +: WIDTH] <= w_next;
          idx                             <= idx + IDX_W'(1);
        end
        BIAS: begin
          bias_out  <= b_next;
          delta_out <= delta_reg;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.READY_OUT   = ready;
  assign bus.WEIGHTS_OUT = weights_out;
  assign bus.BIAS_OUT    = bias_out;
  assign bus.DELTA_OUT   = delta_out;
  assign bus.VALID_OUT   = valid_out;

endmodule
